// File: rtl/snake_dir_reader.sv
// Pops one-hot direction commands from the key queue and commits at most one per game tick.
// Latency: empty queue -> step_done 1 cycle after tick; first entry accepted -> 3 cycles; +2 per skipped entry.
// Backpressure: one outstanding pop at a time, never pops an empty queue; ticks arriving while busy are ignored.
module snake_dir_reader #(
   parameter int unsigned DATA_WIDTH = 4,
   parameter int unsigned MAX_SKIP   = 3,
   parameter logic [3:0]  INIT_DIR   = 4'b1000
) (
   input  logic                  Clk,
   input  logic                  Reset_n,
   input  logic                  tick,
   input  logic                  fifo_empty,
   input  logic [DATA_WIDTH-1:0] fifo_read_data,
   output logic                  fifo_read_en,
   output logic [3:0]            dir,
   output logic                  step_done,
   output logic                  busy,
   output logic [7:0]            drop_count
);

   // IDLE waits for a tick, POP issues the read, WAIT consumes the registered read data.
   typedef enum logic [1:0] {
      IDLE = 2'd0,
      POP  = 2'd1,
      WAIT = 2'd2
   } state_t;

   localparam logic [2:0] MAX_SKIP_C = 3'(MAX_SKIP);

   state_t     state_q, state_d;
   logic [2:0] attempt_q, attempt_d;
   logic [3:0] dir_q, dir_d;
   logic       step_done_q, step_done_d;
   logic [7:0] drop_q, drop_d;

   // Only the low nibble carries a direction; wider entries are truncated here.
   logic [3:0] entry;
   logic       entry_onehot;
   logic [3:0] opposite_dir;
   logic       entry_accept;
   logic [2:0] attempt_next;

   assign entry        = fifo_read_data[3:0];
   assign entry_onehot = (entry != 4'd0) && ((entry & (entry - 4'd1)) == 4'd0);
   // Up/down live in bits [1:0], left/right in bits [3:2]; swapping within each pair gives the reversal.
   assign opposite_dir = {dir_q[2], dir_q[3], dir_q[0], dir_q[1]};
   assign entry_accept = entry_onehot && (entry != opposite_dir);
   assign attempt_next = attempt_q + 3'd1;

   // State and datapath registers; reset discards any in-flight pop without signalling completion.
   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         state_q     <= IDLE;
         attempt_q   <= 3'd0;
         dir_q       <= INIT_DIR;
         step_done_q <= 1'b0;
         drop_q      <= 8'd0;
      end else begin
         state_q     <= state_d;
         attempt_q   <= attempt_d;
         dir_q       <= dir_d;
         step_done_q <= step_done_d;
         drop_q      <= drop_d;
      end
   end

   // Next-state, direction commit, drop counting and step completion.
   always_comb begin
      state_d     = state_q;
      attempt_d   = attempt_q;
      dir_d       = dir_q;
      step_done_d = 1'b0;
      drop_d      = drop_q;

      case (state_q)
         IDLE: begin
            if (tick) begin
               if (fifo_empty) begin
                  // Nothing queued: the step resolves immediately with the old direction.
                  step_done_d = 1'b1;
               end else begin
                  attempt_d = 3'd0;
                  state_d   = POP;
               end
            end
         end

         POP: begin
            state_d = WAIT;
         end

         WAIT: begin
            attempt_d = attempt_next;
            if (entry_accept) begin
               dir_d       = entry;
               step_done_d = 1'b1;
               state_d     = IDLE;
            end else begin
               if (drop_q != 8'hFF) begin
                  drop_d = drop_q + 8'd1;
               end
               // fifo_empty here already reflects the pop just completed.
               if ((attempt_next < MAX_SKIP_C) && !fifo_empty) begin
                  state_d = POP;
               end else begin
                  step_done_d = 1'b1;
                  state_d     = IDLE;
               end
            end
         end

         default: begin
            state_d = IDLE;
         end
      endcase
   end

   assign fifo_read_en = (state_q == POP);
   assign busy         = (state_q != IDLE);
   assign dir          = dir_q;
   assign step_done    = step_done_q;
   assign drop_count   = drop_q;

endmodule

// File: tb/tb_snake_dir_reader.sv
// Directed bench for snake_dir_reader with a behavioural queue that has one-cycle registered read data.
// Latency is measured in cycles after the edge that samples tick (cycle 1 = first cycle after that edge).
// The queue model flags any pop issued while it reports empty.
module tb_snake_dir_reader;

   logic       Clk = 1'b0;
   logic       Reset_n = 1'b0;
   logic       tick = 1'b0;
   logic       fifo_empty;
   logic [3:0] fifo_read_data = 4'd0;
   logic       fifo_read_en;
   logic [3:0] dir;
   logic       step_done;
   logic       busy;
   logic [7:0] drop_count;

   int errors = 0;
   int checks = 0;

   always #5 Clk = ~Clk;

   snake_dir_reader #(
      .DATA_WIDTH(4),
      .MAX_SKIP  (3),
      .INIT_DIR  (4'b1000)
   ) dut (
      .Clk           (Clk),
      .Reset_n       (Reset_n),
      .tick          (tick),
      .fifo_empty    (fifo_empty),
      .fifo_read_data(fifo_read_data),
      .fifo_read_en  (fifo_read_en),
      .dir           (dir),
      .step_done     (step_done),
      .busy          (busy),
      .drop_count    (drop_count)
   );

   // Queue model: writes come from the stimulus process, reads from the pop process.
   logic [3:0] mem [0:511];
   int         wr_ptr = 0;
   int         rd_ptr = 0;
   int         bad_pop = 0;
   logic       flush = 1'b0;

   assign fifo_empty = (wr_ptr == rd_ptr);

   always @(posedge Clk) begin
      if (fifo_read_en) begin
         if (fifo_empty) begin
            bad_pop <= bad_pop + 1;
         end else begin
            fifo_read_data <= mem[rd_ptr % 512];
            rd_ptr         <= rd_ptr + 1;
         end
      end
      if (flush) begin
         rd_ptr <= wr_ptr;
      end
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic push(input logic [3:0] v);
      mem[wr_ptr % 512] = v;
      wr_ptr++;
   endtask

   task automatic do_flush();
      @(negedge Clk) flush = 1'b1;
      @(negedge Clk) flush = 1'b0;
   endtask

   // Results of the last observed step.
   int         rd_cnt, rd1, rd2, rd3, sd_cnt, sd_cyc;
   logic [3:0] sd_dir;
   logic       busy1;

   // Pulse tick, then watch a fixed 10-cycle window; optionally re-pulse tick at cycle xtick_at.
   task automatic run_tick(input int xtick_at);
      rd_cnt = 0; rd1 = 0; rd2 = 0; rd3 = 0;
      sd_cnt = 0; sd_cyc = 0; sd_dir = 4'd0; busy1 = 1'b0;
      @(negedge Clk) tick = 1'b1;
      for (int k = 1; k <= 10; k++) begin
         @(negedge Clk);
         if (fifo_read_en) begin
            rd_cnt++;
            if (rd_cnt == 1) rd1 = k;
            else if (rd_cnt == 2) rd2 = k;
            else if (rd_cnt == 3) rd3 = k;
         end
         if (step_done) begin
            sd_cnt++;
            if (sd_cnt == 1) begin
               sd_cyc = k;
               sd_dir = dir;
            end
         end
         if (k == 1) busy1 = busy;
         tick = (k == xtick_at);
      end
   endtask

   initial begin
      repeat (2) @(negedge Clk);
      Reset_n = 1'b1;
      @(negedge Clk);

      // Reset values
      check("rst_dir", dir, 4'b1000);
      check("rst_rden", fifo_read_en, 0);
      check("rst_sd", step_done, 0);
      check("rst_busy", busy, 0);
      check("rst_drop", drop_count, 0);

      // Single valid entry accepted on first pop
      push(4'b0001);
      run_tick(0);
      check("t1_rd1", rd1, 1);
      check("t1_rdcnt", rd_cnt, 1);
      check("t1_busy", busy1, 1);
      check("t1_sdcyc", sd_cyc, 3);
      check("t1_dir", sd_dir, 4'b0001);
      check("t1_drop", drop_count, 0);

      // Turn back to right (0001 -> 1000 is not a reversal)
      push(4'b1000);
      run_tick(0);
      check("t1b_dir", sd_dir, 4'b1000);

      // Reversal dropped, then next entry accepted
      push(4'b0100);
      push(4'b0001);
      run_tick(0);
      check("t2_rd1", rd1, 1);
      check("t2_rd2", rd2, 3);
      check("t2_sdcyc", sd_cyc, 5);
      check("t2_dir", sd_dir, 4'b0001);
      check("t2_drop", drop_count, 1);

      push(4'b1000);
      run_tick(0);
      check("t2b_dir", dir, 4'b1000);

      // MAX_SKIP rejects: zero, multi-hot, multi-hot; fourth entry stays queued
      push(4'b0000);
      push(4'b0011);
      push(4'b0110);
      push(4'b0010);
      run_tick(0);
      check("t3_rdcnt", rd_cnt, 3);
      check("t3_rd3", rd3, 5);
      check("t3_sdcyc", sd_cyc, 7);
      check("t3_dir", sd_dir, 4'b1000);
      check("t3_drop", drop_count, 4);
      check("t3_notempty", fifo_empty, 0);
      do_flush();

      // Empty queue: immediate step_done, no pop, not busy
      run_tick(0);
      check("t4_rdcnt", rd_cnt, 0);
      check("t4_sdcyc", sd_cyc, 1);
      check("t4_busy", busy1, 0);
      check("t4_dir", dir, 4'b1000);

      // Second tick during a pending pop is ignored
      push(4'b0001);
      run_tick(2);
      check("t5_sdcnt", sd_cnt, 1);
      check("t5_rdcnt", rd_cnt, 1);
      check("t5_dir", dir, 4'b0001);

      // Reset asserted in WAIT
      push(4'b1000);
      @(negedge Clk) tick = 1'b1;
      @(negedge Clk) tick = 1'b0;
      @(negedge Clk);
      check("t6_pre_busy", busy, 1);
      Reset_n = 1'b0;
      #1;
      check("t6_rden", fifo_read_en, 0);
      check("t6_busy", busy, 0);
      check("t6_dir", dir, 4'b1000);
      check("t6_drop", drop_count, 0);
      check("t6_sd", step_done, 0);
      @(negedge Clk) Reset_n = 1'b1;
      sd_cnt = 0;
      for (int k = 0; k < 6; k++) begin
         @(negedge Clk);
         if (step_done) sd_cnt++;
      end
      check("t6_no_sd", sd_cnt, 0);
      do_flush();

      // 300 invalid entries -> saturation at 255
      for (int t = 0; t < 100; t++) begin
         push(4'b0000);
         push(4'b0000);
         push(4'b0000);
         run_tick(0);
         if (t == 83) check("t7_drop252", drop_count, 252);
      end
      check("t7_drop_sat", drop_count, 255);
      check("t7_sdcyc", sd_cyc, 7);
      check("t7_dir", dir, 4'b1000);
      check("no_empty_pop", bad_pop, 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
